// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the memory stage controller.
// Holds the FSM state encoding, the data/address width and the
// register-index width used by the top level and the wait timer.
package mem_stage_ctrl_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_WAIT   = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the data memory.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        return the count to zero (takes priority over en_i)
//   en_i         advance the count by one
//   expired_o    the current cycle is the TIMEOUT-th counted cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: saturates at the last slot so it can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {CW{1'b0}};
    end else if (en_i && (cnt_q != CW'(TIMEOUT - 1))) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit pipeline. Issues loads/stores to the
// multi-cycle data memory, stalls upstream while an access is outstanding,
// and owns the MEM/WB register.
// Ports:
//   ex_*        EX/MEM latch contents (held stable by upstream while stalled)
//   mem_*       data memory request/response handshake
//   stall_pipe  freeze PC/IF/ID/EX and EX/MEM this cycle
//   wb_*        MEM/WB register
//   dcache_*    one-cycle request/hit pulses for performance counting
//   err         sticky fault flag (misalignment, read+write, timeout)
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int DW      = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  logic [DW-1:0]    ex_addr,
  input  logic [DW-1:0]    ex_wdata,
  input  logic             ex_reg_write,
  input  logic [REG_W-1:0] ex_target_reg,
  input  logic             ex_halt,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [DW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  input  logic             mem_done,
  input  logic             mem_stall,
  input  logic             mem_hit,
  output logic             stall_pipe,
  output logic             wb_valid,
  output logic             wb_reg_write,
  output logic             wb_halt,
  output logic [REG_W-1:0] wb_target_reg,
  output logic [DW-1:0]    wb_data,
  output logic             dcache_req,
  output logic             dcache_hit,
  output logic             err
);

  state_e state_q, state_d;

  logic             wb_valid_q, wb_valid_d;
  logic             wb_reg_write_q, wb_reg_write_d;
  logic             wb_halt_q, wb_halt_d;
  logic [REG_W-1:0] wb_target_q, wb_target_d;
  logic [DW-1:0]    wb_data_q, wb_data_d;
  logic             err_q, err_d;

  // Outstanding access kept while the memory works.
  logic             hold_load_q, hold_load_d;
  logic             hold_reg_write_q, hold_reg_write_d;
  logic             hold_halt_q, hold_halt_d;
  logic [REG_W-1:0] hold_target_q, hold_target_d;
  logic [DW-1:0]    hold_addr_q, hold_addr_d;

  logic is_mem_s;
  logic is_load_s;
  logic timer_clr_s;
  logic timer_en_s;
  logic timer_expired_s;

  assign is_mem_s  = ex_valid & (ex_mem_read | ex_mem_write);
  // Read together with write is handled as a write.
  assign is_load_s = ex_mem_read & ~ex_mem_write;

  assign timer_en_s  = (state_q == ST_WAIT) & ~mem_done;
  assign timer_clr_s = (state_q != ST_WAIT) | mem_done;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr_s),
    .en_i      (timer_en_s),
    .expired_o (timer_expired_s)
  );

  // Next-state, memory handshake and MEM/WB next values; MEM/WB defaults to a bubble.
  always_comb begin
    state_d          = state_q;
    err_d            = err_q;
    wb_valid_d       = 1'b0;
    wb_reg_write_d   = 1'b0;
    wb_halt_d        = 1'b0;
    wb_target_d      = {REG_W{1'b0}};
    wb_data_d        = {DW{1'b0}};
    hold_load_d      = hold_load_q;
    hold_reg_write_d = hold_reg_write_q;
    hold_halt_d      = hold_halt_q;
    hold_target_d    = hold_target_q;
    hold_addr_d      = hold_addr_q;
    mem_rd           = 1'b0;
    mem_wr           = 1'b0;
    mem_addr         = {DW{1'b0}};
    mem_wdata        = {DW{1'b0}};
    stall_pipe       = 1'b0;
    dcache_req       = 1'b0;
    dcache_hit       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!is_mem_s) begin
          wb_valid_d     = ex_valid;
          wb_reg_write_d = ex_valid & ex_reg_write;
          wb_halt_d      = ex_valid & ex_halt;
          wb_target_d    = ex_target_reg;
          wb_data_d      = ex_addr;
          state_d        = (ex_valid & ex_halt) ? ST_HALTED : ST_IDLE;
        end else if (ex_addr[0]) begin
          // Misaligned access: never reaches memory, retires as a halt.
          err_d       = 1'b1;
          wb_valid_d  = 1'b1;
          wb_halt_d   = 1'b1;
          wb_target_d = ex_target_reg;
          wb_data_d   = ex_addr;
          state_d     = ST_HALTED;
        end else if (mem_stall) begin
          stall_pipe = 1'b1;
        end else begin
          mem_rd     = is_load_s;
          mem_wr     = ex_mem_write;
          mem_addr   = ex_addr;
          mem_wdata  = ex_wdata;
          dcache_req = 1'b1;
          if (ex_mem_read & ex_mem_write) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          if (mem_done) begin
            dcache_hit     = mem_hit;
            wb_valid_d     = 1'b1;
            wb_reg_write_d = ex_reg_write;
            wb_halt_d      = ex_halt;
            wb_target_d    = ex_target_reg;
            wb_data_d      = is_load_s ? mem_rdata : ex_addr;
            state_d        = ex_halt ? ST_HALTED : ST_IDLE;
          end else begin
            hold_load_d      = is_load_s;
            hold_reg_write_d = ex_reg_write;
            hold_halt_d      = ex_halt;
            hold_target_d    = ex_target_reg;
            hold_addr_d      = ex_addr;
            stall_pipe       = 1'b1;
            state_d          = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (mem_done) begin
          dcache_hit     = mem_hit;
          wb_valid_d     = 1'b1;
          wb_reg_write_d = hold_reg_write_q;
          wb_halt_d      = hold_halt_q;
          wb_target_d    = hold_target_q;
          wb_data_d      = hold_load_q ? mem_rdata : hold_addr_q;
          state_d        = hold_halt_q ? ST_HALTED : ST_IDLE;
        end else if (timer_expired_s) begin
          // Memory never answered: give up, retire as a halt and keep upstream frozen.
          err_d       = 1'b1;
          stall_pipe  = 1'b1;
          wb_valid_d  = 1'b1;
          wb_halt_d   = 1'b1;
          wb_target_d = hold_target_q;
          wb_data_d   = hold_addr_q;
          state_d     = ST_HALTED;
        end else begin
          stall_pipe = 1'b1;
        end
      end

      ST_HALTED: begin
        stall_pipe = 1'b1;
      end

      default: begin
        // Unreachable encoding: fail safe into the halted state and flag it.
        stall_pipe = 1'b1;
        err_d      = 1'b1;
        state_d    = ST_HALTED;
      end
    endcase
  end

  // State, MEM/WB, hold and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      wb_valid_q       <= 1'b0;
      wb_reg_write_q   <= 1'b0;
      wb_halt_q        <= 1'b0;
      wb_target_q      <= {REG_W{1'b0}};
      wb_data_q        <= {DW{1'b0}};
      err_q            <= 1'b0;
      hold_load_q      <= 1'b0;
      hold_reg_write_q <= 1'b0;
      hold_halt_q      <= 1'b0;
      hold_target_q    <= {REG_W{1'b0}};
      hold_addr_q      <= {DW{1'b0}};
    end else begin
      state_q          <= state_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_write_q   <= wb_reg_write_d;
      wb_halt_q        <= wb_halt_d;
      wb_target_q      <= wb_target_d;
      wb_data_q        <= wb_data_d;
      err_q            <= err_d;
      hold_load_q      <= hold_load_d;
      hold_reg_write_q <= hold_reg_write_d;
      hold_halt_q      <= hold_halt_d;
      hold_target_q    <= hold_target_d;
      hold_addr_q      <= hold_addr_d;
    end
  end

  assign wb_valid      = wb_valid_q;
  assign wb_reg_write  = wb_reg_write_q;
  assign wb_halt       = wb_halt_q;
  assign wb_target_reg = wb_target_q;
  assign wb_data       = wb_data_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_mem_stage_ctrl;

  localparam int TIMEOUT = 64;

  logic        clk;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_halt;
  logic [15:0] ex_addr, ex_wdata;
  logic [2:0]  ex_target_reg;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_stall, mem_hit;
  logic        stall_pipe;
  logic        wb_valid, wb_reg_write, wb_halt;
  logic [2:0]  wb_target_reg;
  logic [15:0] wb_data;
  logic        dcache_req, dcache_hit, err;

  mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_reg_write(ex_reg_write),
    .ex_target_reg(ex_target_reg), .ex_halt(ex_halt),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall), .mem_hit(mem_hit),
    .stall_pipe(stall_pipe),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_halt(wb_halt),
    .wb_target_reg(wb_target_reg), .wb_data(wb_data),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a pending memory transaction plus halted/error flags.
  bit          m_halted, m_pending, m_err, m_stall_prev;
  int          m_wait_cycles;
  bit          p_load, p_rw, p_halt;
  logic [2:0]  p_tgt;
  logic [15:0] p_addr;
  // Expected combinational outputs this cycle.
  bit          e_rd, e_wr, e_req, e_hit, e_stall;
  logic [15:0] e_addr, e_wdata;
  // Expected MEM/WB after the coming edge.
  bit          n_valid, n_rw, n_halt;
  logic [2:0]  n_tgt;
  logic [15:0] n_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_pending = 1'b0; m_err = 1'b0; m_stall_prev = 1'b0;
    m_wait_cycles = 0;
    n_valid = 1'b0; n_rw = 1'b0; n_halt = 1'b0; n_tgt = 3'd0; n_data = 16'h0000;
  endtask

  task automatic retire(input bit rw, input logic [2:0] tg, input logic [15:0] d, input bit h);
    n_valid = 1'b1; n_rw = rw; n_tgt = tg; n_data = d; n_halt = h;
    m_halted = h;
  endtask

  // Evaluate one cycle of the model from the currently driven inputs.
  task automatic model_cycle();
    bit is_mem, is_load;
    e_rd = 1'b0; e_wr = 1'b0; e_req = 1'b0; e_hit = 1'b0; e_stall = 1'b0;
    e_addr = 16'h0000; e_wdata = 16'h0000;
    n_valid = 1'b0; n_rw = 1'b0; n_halt = 1'b0; n_tgt = 3'd0; n_data = 16'h0000;
    is_mem  = ex_valid && (ex_mem_read || ex_mem_write);
    is_load = ex_mem_read && !ex_mem_write;
    if (m_halted) begin
      e_stall = 1'b1;
    end else if (m_pending) begin
      m_wait_cycles++;
      if (mem_done) begin
        e_hit = mem_hit;
        m_pending = 1'b0;
        retire(p_rw, p_tgt, p_load ? mem_rdata : p_addr, p_halt);
      end else if (m_wait_cycles == TIMEOUT) begin
        e_stall = 1'b1;
        m_err = 1'b1;
        m_pending = 1'b0;
        retire(1'b0, p_tgt, p_addr, 1'b1);
      end else begin
        e_stall = 1'b1;
      end
    end else if (!is_mem) begin
      if (ex_valid) begin
        retire(ex_reg_write, ex_target_reg, ex_addr, ex_halt);
      end else begin
        n_tgt = ex_target_reg; n_data = ex_addr;
      end
    end else if (ex_addr[0]) begin
      m_err = 1'b1;
      retire(1'b0, ex_target_reg, ex_addr, 1'b1);
    end else if (mem_stall) begin
      e_stall = 1'b1;
    end else begin
      e_rd = is_load; e_wr = ex_mem_write; e_req = 1'b1;
      e_addr = ex_addr; e_wdata = ex_wdata;
      if (ex_mem_read && ex_mem_write) m_err = 1'b1;
      if (mem_done) begin
        e_hit = mem_hit;
        retire(ex_reg_write, ex_target_reg, is_load ? mem_rdata : ex_addr, ex_halt);
      end else begin
        m_pending = 1'b1; m_wait_cycles = 0;
        p_load = is_load; p_rw = ex_reg_write; p_halt = ex_halt;
        p_tgt = ex_target_reg; p_addr = ex_addr;
        e_stall = 1'b1;
      end
    end
  endtask

  // One clock cycle: drive (ex_* held while stalled), check outputs, advance.
  task automatic step(input logic v, input logic r, input logic w, input logic [15:0] a,
                      input logic [15:0] wd, input logic rw, input logic [2:0] tg, input logic h,
                      input logic dn, input logic st, input logic hi, input logic [15:0] rd);
    if (!m_stall_prev) begin
      ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_addr = a; ex_wdata = wd;
      ex_reg_write = rw; ex_target_reg = tg; ex_halt = h;
    end
    mem_done = dn; mem_stall = st; mem_hit = hi; mem_rdata = rd;
    model_cycle();
    #1;
    check_eq("mem_rd", {31'd0, mem_rd}, {31'd0, e_rd});
    check_eq("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
    check_eq("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
    check_eq("mem_wdata", {16'd0, mem_wdata}, {16'd0, e_wdata});
    check_eq("stall_pipe", {31'd0, stall_pipe}, {31'd0, e_stall});
    check_eq("dcache_req", {31'd0, dcache_req}, {31'd0, e_req});
    check_eq("dcache_hit", {31'd0, dcache_hit}, {31'd0, e_hit});
    m_stall_prev = e_stall;
    @(posedge clk);
    #1;
    check_eq("wb_valid", {31'd0, wb_valid}, {31'd0, n_valid});
    check_eq("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, n_rw});
    check_eq("wb_halt", {31'd0, wb_halt}, {31'd0, n_halt});
    check_eq("wb_target_reg", {29'd0, wb_target_reg}, {29'd0, n_tgt});
    check_eq("wb_data", {16'd0, wb_data}, {16'd0, n_data});
    check_eq("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // Assert reset away from the edge with quiet inputs and check every output is zero.
  task automatic do_reset();
    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_addr = 16'h0000;
    ex_wdata = 16'h0000; ex_reg_write = 1'b0; ex_target_reg = 3'd0; ex_halt = 1'b0;
    mem_done = 1'b0; mem_stall = 1'b0; mem_hit = 1'b0; mem_rdata = 16'h0000;
    #2;
    check_eq("rst_outputs",
             {16'd0, mem_rd, mem_wr, stall_pipe, wb_valid, wb_reg_write, wb_halt,
              dcache_req, dcache_hit, err, wb_target_reg, 4'd0},
             32'd0);
    check_eq("rst_buses", {wb_data, mem_addr | mem_wdata}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [15:0] a, wd, rd;
    int sel;
    int halted_cycles;
    bit v, r, w, rw, h, dn, st, hi;
    logic [2:0] tg;

    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // ALU result passes straight through.
    step(1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    idle_step();
    // Load completing in the issue cycle with a hit.
    step(1'b1, 1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 3'd5, 1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    // Store completing four cycles after issue, miss.
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, 1'b1, 16'h0080, 16'h5A5A, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 16'h0080, 16'h5A5A, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1111);
    // Memory busy for two cycles at issue, then a two-cycle access.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 1'b0, 16'h0044, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'hC0DE);
    // Stray done with nothing outstanding.
    step(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFFF);
    // Read and write together behave as a write and raise err.
    step(1'b1, 1'b1, 1'b1, 16'h0050, 16'hA5A5, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7777);
    idle_step();
    do_reset();

    // Misaligned load retires as a halt, later instructions are ignored.
    step(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0000, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b1, 16'h2222);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    do_reset();

    // Memory never answers: timeout after TIMEOUT wait cycles.
    for (int i = 0; i < TIMEOUT + 4; i++)
      step(1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_reset();

    // HALT retires once, subsequent instructions are ignored.
    step(1'b1, 1'b0, 1'b0, 16'h0300, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 16'h0304, 16'h0000, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'h3333);
    do_reset();

    // Reset while an access is outstanding, then normal operation resumes.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 16'h0400, 16'h1357, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    do_reset();
    step(1'b1, 1'b0, 1'b0, 16'h0ABC, 16'h0000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Randomized traffic.
    halted_cycles = 0;
    for (int c = 0; c < 2500; c++) begin
      if (m_halted) halted_cycles++;
      else halted_cycles = 0;
      if (halted_cycles > 3 || $urandom_range(0, 199) == 0) begin
        do_reset();
        halted_cycles = 0;
      end
      v   = ($urandom_range(0, 9) < 8);
      sel = $urandom_range(0, 99);
      r   = (sel >= 40 && sel < 70) || (sel >= 95 && sel < 98);
      w   = (sel >= 70 && sel < 98);
      h   = ($urandom_range(0, 99) < 2);
      a   = 16'($urandom);
      if ($urandom_range(0, 49) != 0) a[0] = 1'b0;
      wd  = 16'($urandom);
      rd  = 16'($urandom);
      rw  = $urandom_range(0, 1);
      tg  = 3'($urandom_range(0, 7));
      st  = ($urandom_range(0, 3) == 0);
      hi  = $urandom_range(0, 1);
      dn  = ($urandom_range(0, 9) < 3);
      step(v, r, w, a, wd, rw, tg, h, dn, st, hi, rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage of the 5-stage 16-bit pipeline; sits between the EX/MEM latches and the MEM/WB register, and owns that register.
- Issues loads/stores to the multi-cycle stall data memory (Done/Stall/CacheHit handshake) and stalls upstream stages while an access is outstanding.
- Produces the retire-side signals (reg write, target reg, WB data, halt) plus per-access DCache req/hit pulses for the perf bench.

Parameters:
- TIMEOUT, 64: maximum cycles in WAIT before the error is raised.
- DW, 16: data/address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_addr  in  DW  ALU result / memory address
- ex_wdata  in  DW  store data
- ex_reg_write  in  1  writes register file
- ex_target_reg  in  3  destination register
- ex_halt  in  1  HALT instruction
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request
- mem_addr  out  DW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_done
- mem_done  in  1  access complete
- mem_stall  in  1  memory busy, cannot accept a request
- mem_hit  in  1  cache hit, qualified by mem_done
- stall_pipe  out  1  freeze PC/IF/ID/EX and EX/MEM
- wb_valid, wb_reg_write, wb_halt  out  1 each  MEM/WB register
- wb_target_reg  out  3  MEM/WB register
- wb_data  out  DW  load data if load, else ex_addr
- dcache_req, dcache_hit  out  1 each  one-cycle pulses
- err  out  1  sticky fault

Behaviour:
- Reset: all outputs 0, FSM=IDLE, halted=0, timeout counter=0. Reset mid-access abandons the transaction; no WB update.
- States: IDLE, WAIT, HALTED.
- IDLE, no valid instruction, or a non-memory instruction: MEM/WB loads ex_* next edge, wb_data=ex_addr, 1-cycle latency, stall_pipe=0.
- IDLE, memory instruction, mem_stall=1: no request; stall_pipe=1; stay IDLE; retry each cycle.
- IDLE, memory instruction, mem_stall=0: mem_rd/mem_wr pulse combinationally for one cycle with mem_addr=ex_addr and mem_wdata=ex_wdata; dcache_req=1.
  - mem_done in the same cycle: retire next edge; stall_pipe=0; dcache_hit=mem_hit.
  - Otherwise: latch the request into hold registers, go to WAIT, stall_pipe=1.
- WAIT: mem_rd/mem_wr=0; stall_pipe=1; wb_valid=0 (bubble); counter increments.
  - mem_done: stall_pipe=0 that cycle; MEM/WB captures hold regs plus mem_rdata (loads); dcache_hit=mem_hit; counter cleared; go to IDLE.
- Read and write both set: treat as a write, set err.
- ex_addr[0]=1 on a memory instruction: no request; err=1; retire as wb_halt=1; go to HALTED.
- Counter reaches TIMEOUT in WAIT: err=1; retire with wb_halt=1; go to HALTED.
- mem_done outside WAIT and without a request: ignored.
- ex_halt retires like a non-memory instruction (wb_halt=1 for one cycle), then HALTED.
- HALTED: ignores all inputs; wb_* stay 0; stall_pipe=1; exit only by rst_n.
- err: sticky until reset.
- ex_* are stable while stall_pipe=1 (upstream guarantee).

Decomposition:
- Shared package: FSM state encoding (2 bits), DW, the register-index width (3).
- One sub-module, mem_wait_timer: the TIMEOUT counter with clear/enable/expired.

Test Plan:
- ALU op ex_addr=0x1234, reg_write, target 3, no memory -> next cycle wb_valid=1, wb_target_reg=3, wb_data=0x1234, stall_pipe never 1.
- Load 0x0040 with mem_done+mem_hit the same cycle, rdata 0xBEEF -> one mem_rd pulse, no stall, wb_data=0xBEEF, dcache_req=1, dcache_hit=1.
- Store 0x0080 data 0x5A5A, mem_done 4 cycles later, mem_hit=0 -> one mem_wr pulse, stall_pipe=1 for exactly 4 cycles, 4 bubbles, dcache_hit=0.
- mem_stall=1 for 2 cycles at issue -> no request for 2 cycles, mem_rd asserted on the 3rd cycle, then normal completion.
- Load to 0x0041 -> no mem_rd, err=1, wb_halt=1 once, then HALTED; never mem_done -> err after TIMEOUT=64 WAIT cycles, wb_halt=1.
- HALT, then further valid instructions -> wb_halt pulses once, later inputs ignored; deassert rst_n during WAIT -> all outputs 0, IDLE.
